// File: rtl/mux8_serial_ctrl.sv
// Byte-to-bit serializer control around an external 8:1 mux: holds the accepted
// byte on mux_in and steps mux_sel once per accepted serial beat.
module mux8_serial_ctrl #(
  parameter bit         MSB_FIRST = 1'b0,
  parameter logic [2:0] IDLE_SEL  = 3'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_data,
  output logic [7:0] mux_in,
  output logic [2:0] mux_sel,
  input  logic       mux_out,
  output logic       ser_data,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       ser_last,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [2:0] START_SEL = MSB_FIRST ? 3'd7 : 3'd0;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [2:0] sel_nxt;
  logic [7:0] in_nxt;
  logic       cnt_last;

  assign cnt_last = (cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      mux_sel <= IDLE_SEL;
      mux_in  <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mux_sel <= sel_nxt;
      mux_in  <= in_nxt;
    end
  end

  // A completed byte can be replaced in the same cycle, so there is no idle bubble.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = mux_sel;
    in_nxt    = mux_in;
    case (state)
      IDLE: begin
        if (load_valid) begin
          state_nxt = SHIFT;
          cnt_nxt   = 3'd0;
          sel_nxt   = START_SEL;
          in_nxt    = load_data;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (!cnt_last) begin
            cnt_nxt = cnt + 3'd1;
            sel_nxt = MSB_FIRST ? (mux_sel - 3'd1) : (mux_sel + 3'd1);
          end else if (load_valid) begin
            cnt_nxt = 3'd0;
            sel_nxt = START_SEL;
            in_nxt  = load_data;
          end else begin
            state_nxt = IDLE;
            sel_nxt   = IDLE_SEL;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = IDLE_SEL;
      end
    endcase
  end

  // load_ready stays low while reset is held, even though the state reads IDLE.
  always_comb begin
    ser_valid  = (state == SHIFT);
    busy       = (state == SHIFT);
    ser_last   = (state == SHIFT) && cnt_last;
    ser_data   = mux_out;
    load_ready = rst_n && ((state == IDLE) || ((state == SHIFT) && cnt_last && ser_ready));
  end

endmodule

// File: tb/tb_mux8_serial_ctrl.sv
// Randomized self-checking bench: two serializers (LSB-first and MSB-first) share
// one stimulus stream and are compared against a beat-level reference model.
module tb_mux8_serial_ctrl;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       ser_ready;

  logic       load_ready0, ser_data0, ser_valid0, ser_last0, busy0, mux_out0;
  logic [7:0] mux_in0;
  logic [2:0] mux_sel0;
  logic       load_ready1, ser_data1, ser_valid1, ser_last1, busy1, mux_out1;
  logic [7:0] mux_in1;
  logic [2:0] mux_sel1;

  int testsRun = 0;
  int testsFailed = 0;

  // reference model: beat index within the current byte
  bit         active;
  int         beat;
  logic [7:0] curByte;
  int         completedBytes;
  int         abortedBeats;
  int         seenBeats;
  int         seenLasts;
  int         phase;
  logic [7:0] txq[$];

  assign mux_out0 = mux_in0[mux_sel0];
  assign mux_out1 = mux_in1[mux_sel1];

  mux8_serial_ctrl #(.MSB_FIRST(1'b0), .IDLE_SEL(3'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready0),
    .load_data(load_data), .mux_in(mux_in0), .mux_sel(mux_sel0), .mux_out(mux_out0),
    .ser_data(ser_data0), .ser_valid(ser_valid0), .ser_ready(ser_ready),
    .ser_last(ser_last0), .busy(busy0)
  );

  mux8_serial_ctrl #(.MSB_FIRST(1'b1), .IDLE_SEL(3'd5)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready1),
    .load_data(load_data), .mux_in(mux_in1), .mux_sel(mux_sel1), .mux_out(mux_out1),
    .ser_data(ser_data1), .ser_valid(ser_valid1), .ser_ready(ser_ready),
    .ser_last(ser_last1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready0"}, load_ready0, 0);
    checkOutput({tag, "_ready1"}, load_ready1, 0);
    checkOutput({tag, "_valid0"}, ser_valid0, 0);
    checkOutput({tag, "_valid1"}, ser_valid1, 0);
    checkOutput({tag, "_last0"}, ser_last0, 0);
    checkOutput({tag, "_busy0"}, busy0, 0);
    checkOutput({tag, "_busy1"}, busy1, 0);
    checkOutput({tag, "_sel0"}, mux_sel0, 0);
    checkOutput({tag, "_sel1"}, mux_sel1, 5);
    checkOutput({tag, "_in0"}, mux_in0, 8'h00);
    checkOutput({tag, "_in1"}, mux_in1, 8'h00);
  endtask

  // readyMode: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
  task automatic applyStimulus(input int readyMode);
    bit expReady;
    bit accept;
    load_valid = (txq.size() != 0);
    load_data  = load_valid ? txq[0] : 8'($urandom);
    case (readyMode)
      0:       ser_ready = 1'b1;
      1:       ser_ready = (phase % 3 == 0);
      default: ser_ready = 1'($urandom_range(0, 1));
    endcase
    phase++;

    @(negedge clk);
    expReady = !active || (beat == 7 && ser_ready);
    checkOutput("load_ready0", load_ready0, expReady);
    checkOutput("load_ready1", load_ready1, expReady);
    checkOutput("ser_valid0", ser_valid0, active);
    checkOutput("ser_valid1", ser_valid1, active);
    checkOutput("busy0", busy0, active);
    checkOutput("ser_last0", ser_last0, active && beat == 7);
    checkOutput("ser_last1", ser_last1, active && beat == 7);
    checkOutput("mux_in0", mux_in0, curByte);
    checkOutput("mux_in1", mux_in1, curByte);
    checkOutput("mux_sel0", mux_sel0, active ? beat : 0);
    checkOutput("mux_sel1", mux_sel1, active ? 7 - beat : 5);
    if (active) begin
      checkOutput("ser_data0", ser_data0, curByte[beat]);
      checkOutput("ser_data1", ser_data1, curByte[7 - beat]);
    end
    if (ser_valid0 && ser_ready) seenBeats++;
    if (ser_valid0 && ser_ready && ser_last0) seenLasts++;

    accept = active && ser_ready;
    if (!active) begin
      if (load_valid) begin
        curByte = load_data; active = 1'b1; beat = 0;
        void'(txq.pop_front());
      end
    end else if (accept) begin
      if (beat < 7) beat++;
      else begin
        completedBytes++;
        if (load_valid) begin
          curByte = load_data; beat = 0;
          void'(txq.pop_front());
        end else active = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int readyMode, input int budget);
    int n = 0;
    while ((txq.size() != 0 || active) && n < budget) begin
      applyStimulus(readyMode);
      n++;
    end
    checkOutput("drain_timeout", (txq.size() != 0 || active), 0);
  endtask

  initial begin
    active = 1'b0; beat = 0; curByte = 8'h00;
    completedBytes = 0; abortedBeats = 0; seenBeats = 0; seenLasts = 0; phase = 0;
    rst_n = 1'b0; load_valid = 1'b1; load_data = 8'hA5; ser_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkResetValues("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_ready0", load_ready0, 1);
    checkOutput("rst_release_ready1", load_ready1, 1);
    load_valid = 1'b0;
    @(posedge clk);
    #1;

    txq.push_back(8'hA5);
    drain(0, 50);
    applyStimulus(0);
    txq.push_back(8'h81);
    drain(0, 50);
    txq.push_back(8'h3C);
    drain(1, 100);
    txq.push_back(8'hFF);
    txq.push_back(8'h00);
    drain(0, 60);

    // abort a byte after three accepted beats
    txq.push_back(8'hF0);
    repeat (4) applyStimulus(0);
    checkOutput("abort_beat", beat, 3);
    abortedBeats = beat;
    rst_n = 1'b0;
    load_valid = 1'b0;
    #1;
    checkResetValues("rst_mid");
    active = 1'b0; beat = 0; curByte = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    txq.push_back(8'h0F);
    drain(0, 50);

    for (int i = 0; i < 40; i++) txq.push_back(8'($urandom));
    drain(2, 2000);
    for (int i = 0; i < 200; i++) begin
      if (txq.size() == 0 && $urandom_range(0, 3) == 0) txq.push_back(8'($urandom));
      applyStimulus(2);
    end
    drain(0, 50);
    applyStimulus(0);

    checkOutput("beat_total", seenBeats, 8 * completedBytes + abortedBeats);
    checkOutput("last_total", seenLasts, completedBytes);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
